// File: rtl/alu_microseq_ctrl_if.sv
// Bundle between a host and the micro-program sequencer.
//   master : host side; loads program words, issues start, observes datapath controls.
//   slave  : sequencer side; accepts program/start, drives SELA/SELB/SELD/OPR/Load,
//            Busy/Done status and the debug PC.
// Program word layout: {halt[14], sela[13:11], selb[10:8], seld[7:5], opr[4:0]}.
interface alu_microseq_ctrl_if #(
    parameter int unsigned AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [14:0]   prog_data;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [2:0]    sela;
    logic [2:0]    selb;
    logic [2:0]    seld;
    logic [4:0]    opr;
    logic          load;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    modport master (
        output prog_we, prog_addr, prog_data, start, start_addr,
        input  sela, selb, seld, opr, load, busy, done, pc
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, start_addr,
        output sela, selb, seld, opr, load, busy, done, pc
    );
endinterface

// File: rtl/alu_microseq_ctrl.sv
// Micro-program sequencer for the 8-register / 32-op ALU datapath.
// Holds a DEPTH-word loadable program; on start it steps from start_addr, spending
// FETCH, EXEC and WRITE cycles per micro-op, then pulses done for one cycle.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst   : synchronous active-high reset (program memory is not cleared)
//   io_bus  : slave side of alu_microseq_ctrl_if (program load, start, datapath controls,
//             busy/done status, debug pc)
module alu_microseq_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    alu_microseq_ctrl_if.slave  io_bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [2:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [14:0]   r_ir;
    logic [2:0]    r_seld;
    logic [14:0]   r_mem [DEPTH];

    logic w_mem_we;
    logic w_last_step;

    // Writes are only accepted while idle; a write in the start cycle lands before FETCH reads.
    assign w_mem_we    = io_bus.prog_we && (r_state == S_IDLE);
    assign w_last_step = r_ir[14] || (r_pc == LAST_ADDR);

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[io_bus.prog_addr] <= io_bus.prog_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_seld  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_pc    <= io_bus.start_addr;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_seld  <= r_ir[7:5];
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    // No wrap past the last word: it ends the program like a halt.
                    if (w_last_step) begin
                        r_state <= S_DONE;
                    end else begin
                        r_pc    <= r_pc + AW'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A/B/op selects come straight from IR so they stay stable through the Load edge
    // and keep their last values while idle.
    assign io_bus.sela = r_ir[13:11];
    assign io_bus.selb = r_ir[10:8];
    assign io_bus.opr  = r_ir[4:0];
    assign io_bus.seld = r_seld;
    // Reset suppresses the register write in the very cycle it is asserted.
    assign io_bus.load = (r_state == S_WRITE) && (r_seld != 3'd0) && !i_rst;
    assign io_bus.busy = (r_state != S_IDLE);
    assign io_bus.done = (r_state == S_DONE);
    assign io_bus.pc   = r_pc;

endmodule

// File: tb/tb_alu_microseq_ctrl.sv
// Self-checking bench for alu_microseq_ctrl: directed scenarios plus randomized programs,
// compared cycle by cycle against a step-list reference model and a small datapath model.
module tb_alu_microseq_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_microseq_ctrl_if #(.AW(AW)) bus ();

    alu_microseq_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] mirror [DEPTH];
    logic [7:0]  dp_reg [8];
    logic [7:0]  dp_input = 8'd5;
    logic        dp_init  = 1'b0;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [4:0] op);
        case (op)
            5'd0:    return a + b;
            5'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    // Datapath model: register file written by the sequencer's Load on the clock edge.
    always @(posedge clk) begin
        if (dp_init) begin
            for (int i = 0; i < 8; i++) dp_reg[i] <= (i == 1) ? 8'd125 : 8'd0;
        end else if (bus.load && bus.seld != 3'd0) begin
            dp_reg[bus.seld] <= alu((bus.sela == 3'd0) ? dp_input : dp_reg[bus.sela],
                                    (bus.selb == 3'd0) ? dp_input : dp_reg[bus.selb],
                                    bus.opr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] enc(input logic h, input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] d, input logic [4:0] op);
        return {h, a, b, d, op};
    endfunction

    task automatic prog_write(input logic [AW-1:0] addr, input logic [14:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(posedge clk); #1;
        bus.prog_we   = 1'b0;
        mirror[addr]  = data;
    endtask

    task automatic reset_dp();
        dp_init = 1'b1;
        @(posedge clk); #1;
        dp_init = 1'b0;
    endtask

    // mode 0: plain run; 1: extra start + ignored write during busy; 2: write in start cycle
    task automatic run_check(input logic [AW-1:0] sa, input int mode,
                             input logic [AW-1:0] we_addr, input logic [14:0] we_data);
        int steps[$];
        int n;
        int ncyc;
        int s;
        int ph;
        logic [14:0] w;
        logic exp_load;
        if (mode == 2) mirror[we_addr] = we_data;
        // Reference: list of addresses executed, ending at a halt word or the last address.
        for (int k = int'(sa); k < int'(DEPTH); k++) begin
            steps.push_back(k);
            if (mirror[k][14]) break;
        end
        n    = steps.size();
        ncyc = 3 * n + 2;
        bus.start      = 1'b1;
        bus.start_addr = sa;
        if (mode == 2) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = we_addr;
            bus.prog_data = we_data;
        end
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            exp_load = 1'b0;
            if (c >= 1 && c <= 3 * n) begin
                s  = (c - 1) / 3;
                ph = (c - 1) % 3;
                w  = mirror[steps[s]];
                check_eq($sformatf("sa%0d c%0d pc", sa, c), 32'(bus.pc), 32'(steps[s]));
                if (ph >= 1) begin
                    check_eq($sformatf("sa%0d c%0d sela", sa, c), 32'(bus.sela), 32'(w[13:11]));
                    check_eq($sformatf("sa%0d c%0d selb", sa, c), 32'(bus.selb), 32'(w[10:8]));
                    check_eq($sformatf("sa%0d c%0d opr", sa, c), 32'(bus.opr), 32'(w[4:0]));
                end
                if (ph == 2) begin
                    check_eq($sformatf("sa%0d c%0d seld", sa, c), 32'(bus.seld), 32'(w[7:5]));
                    exp_load = (w[7:5] != 3'd0);
                end
            end
            if (c == 3 * n + 1) begin
                check_eq($sformatf("sa%0d c%0d done pc", sa, c), 32'(bus.pc), 32'(steps[n-1]));
            end
            check_eq($sformatf("sa%0d c%0d busy", sa, c), 32'(bus.busy),
                     32'(c >= 1 && c <= 3 * n + 1));
            check_eq($sformatf("sa%0d c%0d done", sa, c), 32'(bus.done), 32'(c == 3 * n + 1));
            check_eq($sformatf("sa%0d c%0d load", sa, c), 32'(bus.load), 32'(exp_load));
            @(posedge clk); #1;
            bus.start   = 1'b0;
            bus.prog_we = 1'b0;
            if (mode == 1 && c + 1 == 2) begin
                bus.start      = 1'b1;
                bus.start_addr = AW'($urandom);
                bus.prog_we    = 1'b1;
                bus.prog_addr  = we_addr;
                bus.prog_data  = we_data;
            end
        end
    endtask

    logic [7:0]  r7_before;
    logic [14:0] wd;

    initial begin
        rst            = 1'b1;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.start      = 1'b1;  // reset must win over start
        bus.start_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset busy", 32'(bus.busy), 32'd0);
        check_eq("reset done", 32'(bus.done), 32'd0);
        check_eq("reset load", 32'(bus.load), 32'd0);
        check_eq("reset pc", 32'(bus.pc), 32'd0);
        check_eq("reset sela", 32'(bus.sela), 32'd0);
        check_eq("reset selb", 32'(bus.selb), 32'd0);
        check_eq("reset seld", 32'(bus.seld), 32'd0);
        check_eq("reset opr", 32'(bus.opr), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst       = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) prog_write(AW'(i), {1'b0, 14'($urandom)});
        reset_dp();

        // Input + R1 -> R7, then R7 + R7 -> R7 with halt: 130, then 260 mod 256 = 4.
        prog_write(AW'(0), enc(1'b0, 3'd0, 3'd1, 3'd7, 5'd0));
        prog_write(AW'(1), enc(1'b1, 3'd7, 3'd7, 3'd7, 5'd0));
        run_check(AW'(0), 0, '0, '0);
        check_eq("t1 r7", 32'(dp_reg[7]), 32'd4);

        // SELD=0 step: no register changes, PC still advances.
        prog_write(AW'(2), enc(1'b0, 3'd1, 3'd1, 3'd0, 5'd2));
        prog_write(AW'(3), enc(1'b1, 3'd0, 3'd0, 3'd0, 5'd0));
        run_check(AW'(2), 0, '0, '0);
        check_eq("t2 r1", 32'(dp_reg[1]), 32'd125);
        check_eq("t2 r7", 32'(dp_reg[7]), 32'd4);

        // Full program without halt, start two words from the end.
        for (int i = 0; i < int'(DEPTH); i++)
            prog_write(AW'(i), enc(1'b0, 3'($urandom), 3'($urandom),
                                   3'($urandom_range(1, 7)), 5'($urandom)));
        run_check(AW'(DEPTH - 2), 0, '0, '0);
        check_eq("t3 pc end", 32'(bus.pc), 32'(DEPTH - 1));

        // Write and start during busy are ignored; rerun sees the original program.
        prog_write(AW'(2), enc(1'b1, 3'd3, 3'd4, 3'd5, 5'd6));
        run_check(AW'(0), 1, AW'(0), enc(1'b1, 3'd7, 3'd7, 3'd0, 5'd31));
        run_check(AW'(0), 0, '0, '0);

        // Reset during EXEC of the first step aborts without a write.
        prog_write(AW'(0), enc(1'b0, 3'd0, 3'd1, 3'd7, 5'd0));
        prog_write(AW'(1), enc(1'b1, 3'd7, 3'd7, 3'd7, 5'd0));
        reset_dp();
        bus.start      = 1'b1;
        bus.start_addr = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b1;
        r7_before = dp_reg[7];
        @(negedge clk);
        check_eq("t5 exec busy", 32'(bus.busy), 32'd1);
        check_eq("t5 exec load", 32'(bus.load), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5 busy", 32'(bus.busy), 32'd0);
        check_eq("t5 load", 32'(bus.load), 32'd0);
        check_eq("t5 done", 32'(bus.done), 32'd0);
        check_eq("t5 pc", 32'(bus.pc), 32'd0);
        check_eq("t5 sela", 32'(bus.sela), 32'd0);
        check_eq("t5 r7", 32'(dp_reg[7]), 32'(r7_before));
        @(posedge clk); #1;
        run_check(AW'(0), 0, '0, '0);
        check_eq("t5 rerun r7", 32'(dp_reg[7]), 32'd4);

        // Start and write at the same address in one cycle: the new word runs first.
        run_check(AW'(5), 2, AW'(5), enc(1'b1, 3'd2, 3'd3, 3'd6, 5'd9));

        // Randomized programs, start addresses and disturbances.
        for (int it = 0; it < 24; it++) begin
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                wd = 15'($urandom);
                wd[14] = ($urandom_range(0, 3) == 0);
                prog_write(AW'($urandom), wd);
            end
            wd = 15'($urandom);
            wd[14] = ($urandom_range(0, 1) == 0);
            begin
                logic [AW-1:0] sa;
                int mode;
                sa   = AW'($urandom);
                mode = int'($urandom_range(0, 2));
                run_check(sa, mode, (mode == 2) ? sa : AW'($urandom), wd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
